// File: rtl/pipe_ctrl_hazard_unit_pkg.sv
// Shared encodings for the pipelined TSC control/hazard unit: opcodes, control
// field codes, the halt FSM states and the decoded-instruction bundle.
package pipe_ctrl_hazard_unit_pkg;

  localparam logic [3:0] OPC_BNE   = 4'd0;
  localparam logic [3:0] OPC_BEQ   = 4'd1;
  localparam logic [3:0] OPC_BGZ   = 4'd2;
  localparam logic [3:0] OPC_BLZ   = 4'd3;
  localparam logic [3:0] OPC_ADI   = 4'd4;
  localparam logic [3:0] OPC_ORI   = 4'd5;
  localparam logic [3:0] OPC_LHI   = 4'd6;
  localparam logic [3:0] OPC_LWD   = 4'd7;
  localparam logic [3:0] OPC_SWD   = 4'd8;
  localparam logic [3:0] OPC_JMP   = 4'd9;
  localparam logic [3:0] OPC_JAL   = 4'd10;
  localparam logic [3:0] OPC_RTYPE = 4'd15;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_2  = 2'd2;

  localparam logic [1:0] ALUSRCB_REG  = 2'd0;
  localparam logic [1:0] ALUSRCB_IMM  = 2'd1;
  localparam logic [1:0] ALUSRCB_ZERO = 2'd2;

  localparam logic [1:0] REGWRITESRC_ALU = 2'd0;
  localparam logic [1:0] REGWRITESRC_MEM = 2'd1;
  localparam logic [1:0] REGWRITESRC_PC  = 2'd2;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_REG    = 2'd2;
  localparam logic [1:0] PCSRC_BRANCH = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_TCP = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LHI = 4'd8;

  typedef enum logic [1:0] {
    HALT_RUN   = 2'd0,
    HALT_DRAIN = 2'd1,
    HALT_DONE  = 2'd2
  } haltState_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memToReg;
    logic [1:0] pcSource;
  } ctrlBundle_t;

  typedef struct packed {
    ctrlBundle_t ctrl;
    logic        usesRs;
    logic        usesRt;
    logic        isLoad;
    logic        isWwd;
    logic        isBranch;
    logic        isJump;
    logic        isHlt;
  } decode_t;

endpackage

// File: rtl/pipe_ctrl_hazard_unit_if.sv
// Bus between the pipeline datapath (master) and the control/hazard unit (slave).
interface pipe_ctrl_hazard_unit_if #(
  parameter int NUM_REG_W  = 2,
  parameter int INST_CNT_W = 16
);
  import pipe_ctrl_hazard_unit_pkg::*;

  // id_valid qualifies the id_* fields; pc_en/ifid_en low means the datapath
  // must hold PC and IF/ID so the same instruction is presented next cycle.
  logic                  id_valid;
  logic [3:0]            id_opcode;
  logic [5:0]            id_func_code;
  logic [NUM_REG_W-1:0]  id_rs;
  logic [NUM_REG_W-1:0]  id_rt;
  logic [NUM_REG_W-1:0]  id_rd;
  logic                  ex_branch_taken;

  logic                  id_reg_write;
  logic [1:0]            id_reg_dst;
  logic [1:0]            id_alu_src_b;
  logic [3:0]            id_alu_op;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic [1:0]            id_mem_to_reg;
  logic [1:0]            id_pc_source;
  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  output_active;
  logic                  is_halted;
  logic [INST_CNT_W-1:0] num_inst;
  haltState_t            dbg_state;

  modport master (
    output id_valid, id_opcode, id_func_code, id_rs, id_rt, id_rd, ex_branch_taken,
    input  id_reg_write, id_reg_dst, id_alu_src_b, id_alu_op, id_mem_read,
           id_mem_write, id_mem_to_reg, id_pc_source, pc_en, ifid_en, ifid_flush,
           idex_bubble, output_active, is_halted, num_inst, dbg_state
  );

  modport slave (
    input  id_valid, id_opcode, id_func_code, id_rs, id_rt, id_rd, ex_branch_taken,
    output id_reg_write, id_reg_dst, id_alu_src_b, id_alu_op, id_mem_read,
           id_mem_write, id_mem_to_reg, id_pc_source, pc_en, ifid_en, ifid_flush,
           idex_bubble, output_active, is_halted, num_inst, dbg_state
  );

endinterface

// File: rtl/pipe_ctrl_hazard_unit_ctrl_decoder.sv
// Combinational TSC decode: opcode/func to control bundle plus source-use and
// instruction-class flags consumed by the hazard scoreboard.
module ctrl_decoder
  import pipe_ctrl_hazard_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] funcCode,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OPC_RTYPE: begin
        case (funcCode)
          FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
          FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: begin
            dec.ctrl.regWrite = 1'b1;
            dec.ctrl.regDst   = REGDST_RD;
            dec.ctrl.aluSrcB  = ALUSRCB_REG;
            dec.ctrl.aluOp    = {1'b0, funcCode[2:0]};
            dec.usesRs        = 1'b1;
            // Unary ops (NOT/TCP/SHL/SHR) ignore rt.
            dec.usesRt        = (funcCode[2] == 1'b0);
          end
          FUNC_JPR: begin
            dec.ctrl.pcSource = PCSRC_REG;
            dec.usesRs        = 1'b1;
            dec.isJump        = 1'b1;
          end
          FUNC_JRL: begin
            dec.ctrl.pcSource = PCSRC_REG;
            dec.ctrl.regWrite = 1'b1;
            dec.ctrl.regDst   = REGDST_2;
            dec.ctrl.memToReg = REGWRITESRC_PC;
            dec.usesRs        = 1'b1;
            dec.isJump        = 1'b1;
          end
          FUNC_WWD: begin
            dec.usesRs = 1'b1;
            dec.isWwd  = 1'b1;
          end
          FUNC_HLT: dec.isHlt = 1'b1;
          default: ;
        endcase
      end
      OPC_ADI, OPC_ORI, OPC_LHI: begin
        dec.ctrl.regWrite = 1'b1;
        dec.ctrl.regDst   = REGDST_RT;
        dec.ctrl.aluSrcB  = ALUSRCB_IMM;
        dec.ctrl.aluOp    = (opcode == OPC_ADI) ? OP_ADD :
                            (opcode == OPC_ORI) ? OP_ORR : OP_LHI;
        dec.usesRs        = (opcode != OPC_LHI);
      end
      OPC_LWD: begin
        dec.ctrl.regWrite = 1'b1;
        dec.ctrl.regDst   = REGDST_RT;
        dec.ctrl.aluSrcB  = ALUSRCB_IMM;
        dec.ctrl.aluOp    = OP_ADD;
        dec.ctrl.memRead  = 1'b1;
        dec.ctrl.memToReg = REGWRITESRC_MEM;
        dec.usesRs        = 1'b1;
        dec.isLoad        = 1'b1;
      end
      OPC_SWD: begin
        dec.ctrl.aluSrcB  = ALUSRCB_IMM;
        dec.ctrl.aluOp    = OP_ADD;
        dec.ctrl.memWrite = 1'b1;
        dec.usesRs        = 1'b1;
        dec.usesRt        = 1'b1;
      end
      OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ: begin
        dec.ctrl.aluSrcB  = (opcode == OPC_BNE || opcode == OPC_BEQ) ? ALUSRCB_REG : ALUSRCB_ZERO;
        dec.ctrl.aluOp    = OP_SUB;
        dec.ctrl.pcSource = PCSRC_BRANCH;
        dec.usesRs        = 1'b1;
        dec.usesRt        = (opcode == OPC_BNE || opcode == OPC_BEQ);
        dec.isBranch      = 1'b1;
      end
      OPC_JMP: begin
        dec.ctrl.pcSource = PCSRC_JUMP;
        dec.isJump        = 1'b1;
      end
      OPC_JAL: begin
        dec.ctrl.pcSource = PCSRC_JUMP;
        dec.ctrl.regWrite = 1'b1;
        dec.ctrl.regDst   = REGDST_2;
        dec.ctrl.memToReg = REGWRITESRC_PC;
        dec.isJump        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// Pipelined control unit: decode, in-flight writer scoreboard, stall/flush/bubble
// generation, WB retirement counting and the HLT drain FSM.
module pipe_ctrl_hazard_unit
  import pipe_ctrl_hazard_unit_pkg::*;
#(
  parameter int NUM_REG_W  = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int FORWARD_EN = 1,
  parameter int INST_CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_ctrl_hazard_unit_if.slave bus
);

  typedef struct packed {
    logic                 valid;
    logic                 regWrite;
    logic [NUM_REG_W-1:0] dst;
    logic                 isLoad;
    logic                 isWwd;
    logic                 isBranch;
  } sbEntry_t;

  decode_t               dec;
  sbEntry_t              sb [PIPE_DEPTH];
  haltState_t            state, stateNext;
  logic [NUM_REG_W-1:0]  idDst;
  logic [INST_CNT_W-1:0] numInst;
  logic                  rawHazard, anyValid;
  logic                  inRun, branchFlush, stall, hltTake, jumpTake, bubble, accept;
  ctrlBundle_t           ctrlOut;

  ctrl_decoder uDecoder (
    .opcode   (bus.id_opcode),
    .funcCode (bus.id_func_code),
    .dec      (dec)
  );

  always_comb begin
    case (dec.ctrl.regDst)
      REGDST_RD: idDst = bus.id_rd;
      REGDST_2:  idDst = NUM_REG_W'(2);
      default:   idDst = bus.id_rt;
    endcase
  end

  // The WB entry is never a hazard: the register file writes before it reads.
  always_comb begin
    rawHazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
      if ((FORWARD_EN == 0 || (i == 0 && sb[i].isLoad)) && sb[i].valid && sb[i].regWrite &&
          ((dec.usesRs && sb[i].dst == bus.id_rs) || (dec.usesRt && sb[i].dst == bus.id_rt)))
        rawHazard = 1'b1;
    end
    rawHazard = rawHazard && bus.id_valid;
  end

  always_comb begin
    anyValid = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) anyValid = anyValid | sb[i].valid;
  end

  // A taken branch in EX squashes whatever sits in ID, so it overrides stalls.
  assign inRun       = (state == HALT_RUN);
  assign branchFlush = inRun && sb[0].valid && sb[0].isBranch && bus.ex_branch_taken;
  assign stall       = inRun && rawHazard && !branchFlush;
  assign hltTake     = inRun && bus.id_valid && dec.isHlt && !branchFlush;
  assign jumpTake    = inRun && bus.id_valid && dec.isJump && !rawHazard && !branchFlush;
  assign bubble      = branchFlush || stall;
  assign accept      = inRun && bus.id_valid && !bubble && !dec.isHlt;
  assign ctrlOut     = (bus.id_valid && !bubble) ? dec.ctrl : '0;

  always_comb begin
    stateNext = state;
    case (state)
      HALT_RUN:   if (hltTake) stateNext = HALT_DRAIN;
      HALT_DRAIN: if (!anyValid) stateNext = HALT_DONE;
      HALT_DONE:  stateNext = HALT_DONE;
      default:    stateNext = HALT_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HALT_RUN;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) sb[i] <= '0;
      numInst <= '0;
    end else begin
      sb[0] <= accept ? sbEntry_t'{1'b1, dec.ctrl.regWrite, idDst, dec.isLoad, dec.isWwd,
                                   dec.isBranch}
                      : '0;
      for (int i = 1; i < PIPE_DEPTH; i++) sb[i] <= sb[i-1];
      if (sb[PIPE_DEPTH-1].valid) numInst <= numInst + 1'b1;
    end
  end

  assign bus.id_reg_write  = ctrlOut.regWrite;
  assign bus.id_reg_dst    = ctrlOut.regDst;
  assign bus.id_alu_src_b  = ctrlOut.aluSrcB;
  assign bus.id_alu_op     = ctrlOut.aluOp;
  assign bus.id_mem_read   = ctrlOut.memRead;
  assign bus.id_mem_write  = ctrlOut.memWrite;
  assign bus.id_mem_to_reg = ctrlOut.memToReg;
  assign bus.id_pc_source  = ctrlOut.pcSource;
  assign bus.pc_en         = inRun && !stall && !hltTake;
  assign bus.ifid_en       = inRun && !stall && !hltTake;
  assign bus.ifid_flush    = branchFlush || jumpTake;
  assign bus.idex_bubble   = bubble;
  assign bus.output_active = sb[PIPE_DEPTH-1].valid && sb[PIPE_DEPTH-1].isWwd;
  assign bus.is_halted     = (state == HALT_DONE);
  assign bus.num_inst      = numInst;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Directed bench for pipe_ctrl_hazard_unit: a forwarding and a non-forwarding
// instance share one stimulus stream; retirements are scored from exp_q.
module tb_pipe_ctrl_hazard_unit;
  import pipe_ctrl_hazard_unit_pkg::*;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       idValid;
  logic [3:0] idOpcode;
  logic [5:0] idFunc;
  logic [1:0] idRs, idRt, idRd;
  logic       brTaken;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   expCnt   = 0;
  bit   sbOn     = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl_hazard_unit_if #(.NUM_REG_W(2), .INST_CNT_W(16)) busF ();
  pipe_ctrl_hazard_unit_if #(.NUM_REG_W(2), .INST_CNT_W(16)) busN ();

  assign busF.id_valid = idValid;      assign busN.id_valid = idValid;
  assign busF.id_opcode = idOpcode;    assign busN.id_opcode = idOpcode;
  assign busF.id_func_code = idFunc;   assign busN.id_func_code = idFunc;
  assign busF.id_rs = idRs;            assign busN.id_rs = idRs;
  assign busF.id_rt = idRt;            assign busN.id_rt = idRt;
  assign busF.id_rd = idRd;            assign busN.id_rd = idRd;
  assign busF.ex_branch_taken = brTaken;
  assign busN.ex_branch_taken = brTaken;

  pipe_ctrl_hazard_unit #(.NUM_REG_W(2), .PIPE_DEPTH(DEPTH), .FORWARD_EN(1), .INST_CNT_W(16))
    uFwd (.clk(clk), .reset(reset), .bus(busF.slave));
  pipe_ctrl_hazard_unit #(.NUM_REG_W(2), .PIPE_DEPTH(DEPTH), .FORWARD_EN(0), .INST_CNT_W(16))
    uNoFwd (.clk(clk), .reset(reset), .bus(busN.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic rInst(input logic [5:0] f, input logic [1:0] s, t, d);
    idValid = 1'b1; idOpcode = OPC_RTYPE; idFunc = f; idRs = s; idRt = t; idRd = d;
  endtask

  task automatic iInst(input logic [3:0] o, input logic [1:0] s, t);
    idValid = 1'b1; idOpcode = o; idFunc = 6'(($urandom_range(0, 63))); idRs = s; idRt = t;
    idRd = 2'($urandom_range(0, 3));
  endtask

  task automatic nop();
    idValid = 1'b0; idOpcode = 4'($urandom_range(0, 15)); idFunc = '0;
    idRs = 2'($urandom_range(0, 3)); idRt = 2'($urandom_range(0, 3)); idRd = '0;
  endtask

  // Instruction accepted this cycle reaches WB DEPTH cycles later.
  task automatic expectRetire(input logic wwd);
    exp_q.push_back({31'(cyc + DEPTH), wwd});
  endtask

  task automatic settle();
    logic due;
    logic expOa;
    @(negedge clk);
    if (sbOn) begin
      due   = (exp_q.size() > 0) && (exp_q[0][31:1] == 31'(cyc));
      expOa = due ? exp_q[0][0] : 1'b0;
      chk("num_inst", 32'(busF.num_inst), 32'(expCnt));
      chk("output_active", 32'(busF.output_active), 32'(expOa));
      if (due) begin
        void'(exp_q.pop_front());
        expCnt++;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ctlF(input string tag, input logic pcEn, input logic flush, input logic bub);
    chk({tag, "_pc_en"}, 32'(busF.pc_en), 32'(pcEn));
    chk({tag, "_ifid_en"}, 32'(busF.ifid_en), 32'(pcEn));
    chk({tag, "_flush"}, 32'(busF.ifid_flush), 32'(flush));
    chk({tag, "_bubble"}, 32'(busF.idex_bubble), 32'(bub));
  endtask

  task automatic ctlN(input string tag, input logic pcEn, input logic bub);
    chk({tag, "_pc_en"}, 32'(busN.pc_en), 32'(pcEn));
    chk({tag, "_bubble"}, 32'(busN.idex_bubble), 32'(bub));
  endtask

  task automatic doReset();
    reset = 1'b1;
    nop();
    brTaken = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    expCnt = 0;
    cyc++;
  endtask

  task automatic drain(input int n);
    nop();
    for (int i = 0; i < n; i++) begin
      settle();
      adv();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; brTaken = 1'b0; nop();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sbOn  = 1'b1;

    // Reset state
    settle();
    ctlF("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_halted", 32'(busF.is_halted), 32'd0);
    chk("reset_state", 32'(busF.dbg_state), 32'(HALT_RUN));
    ctlN("reset_nofwd", 1'b1, 1'b0);
    adv();

    // ADD $1 <- $2+$3, then WWD $1
    rInst(FUNC_ADD, 2'd2, 2'd3, 2'd1);
    settle();
    ctlF("add", 1'b1, 1'b0, 1'b0);
    chk("add_reg_write", 32'(busF.id_reg_write), 32'd1);
    chk("add_reg_dst", 32'(busF.id_reg_dst), 32'(REGDST_RD));
    chk("add_alu_src_b", 32'(busF.id_alu_src_b), 32'(ALUSRCB_REG));
    chk("add_alu_op", 32'(busF.id_alu_op), 32'(OP_ADD));
    expectRetire(1'b0);
    adv();
    rInst(FUNC_WWD, 2'd1, 2'd0, 2'd0);
    settle();
    ctlF("wwd", 1'b1, 1'b0, 1'b0);
    chk("wwd_reg_write", 32'(busF.id_reg_write), 32'd0);
    expectRetire(1'b1);
    adv();
    drain(5);

    // Load-use with forwarding: exactly one stall
    iInst(OPC_LWD, 2'd0, 2'd1);
    settle();
    ctlF("lwd", 1'b1, 1'b0, 1'b0);
    chk("lwd_mem_read", 32'(busF.id_mem_read), 32'd1);
    chk("lwd_mem_to_reg", 32'(busF.id_mem_to_reg), 32'(REGWRITESRC_MEM));
    chk("lwd_alu_src_b", 32'(busF.id_alu_src_b), 32'(ALUSRCB_IMM));
    chk("lwd_reg_dst", 32'(busF.id_reg_dst), 32'(REGDST_RT));
    expectRetire(1'b0);
    adv();
    rInst(FUNC_ADD, 2'd1, 2'd0, 2'd2);
    settle();
    ctlF("load_use_stall", 1'b0, 1'b0, 1'b1);
    chk("load_use_ctrl_gated", 32'(busF.id_reg_write), 32'd0);
    adv();
    settle();
    ctlF("load_use_go", 1'b1, 1'b0, 1'b0);
    expectRetire(1'b0);
    adv();
    iInst(OPC_LWD, 2'd0, 2'd1);
    settle();
    expectRetire(1'b0);
    adv();
    iInst(OPC_ADI, 2'd3, 2'd2);
    settle();
    ctlF("load_no_use", 1'b1, 1'b0, 1'b0);
    expectRetire(1'b0);
    adv();
    drain(5);

    // Taken branch squashes the ID instruction
    iInst(OPC_BEQ, 2'd0, 2'd0);
    settle();
    ctlF("beq", 1'b1, 1'b0, 1'b0);
    chk("beq_alu_op", 32'(busF.id_alu_op), 32'(OP_SUB));
    chk("beq_pc_source", 32'(busF.id_pc_source), 32'(PCSRC_BRANCH));
    chk("beq_reg_write", 32'(busF.id_reg_write), 32'd0);
    expectRetire(1'b0);
    adv();
    rInst(FUNC_ADD, 2'd1, 2'd1, 2'd3);
    brTaken = 1'b1;
    settle();
    ctlF("branch_taken", 1'b1, 1'b1, 1'b1);
    chk("branch_squash_ctrl", 32'(busF.id_reg_write), 32'd0);
    adv();
    brTaken = 1'b0;
    iInst(OPC_ADI, 2'd0, 2'd3);
    settle();
    ctlF("branch_target", 1'b1, 1'b0, 1'b0);
    expectRetire(1'b0);
    adv();
    drain(5);

    // JRL $1 behind LWD $1: one stall, then redirect
    iInst(OPC_LWD, 2'd0, 2'd1);
    settle();
    expectRetire(1'b0);
    adv();
    rInst(FUNC_JRL, 2'd1, 2'd0, 2'd0);
    settle();
    ctlF("jrl_stall", 1'b0, 1'b0, 1'b1);
    chk("jrl_stall_pc_source", 32'(busF.id_pc_source), 32'(PCSRC_SEQ));
    adv();
    settle();
    ctlF("jrl_go", 1'b1, 1'b1, 1'b0);
    chk("jrl_pc_source", 32'(busF.id_pc_source), 32'(PCSRC_REG));
    chk("jrl_reg_dst", 32'(busF.id_reg_dst), 32'(REGDST_2));
    chk("jrl_mem_to_reg", 32'(busF.id_mem_to_reg), 32'(REGWRITESRC_PC));
    expectRetire(1'b0);
    adv();
    drain(5);

    // RAW without forwarding: two stalls, third-cycle consumer none
    sbOn = 1'b0;
    doReset();
    iInst(OPC_ADI, 2'd2, 2'd1);
    settle(); ctlN("raw_producer", 1'b1, 1'b0); adv();
    rInst(FUNC_ADD, 2'd1, 2'd1, 2'd2);
    settle(); ctlN("raw_stall1", 1'b0, 1'b1); adv();
    settle(); ctlN("raw_stall2", 1'b0, 1'b1); adv();
    settle(); ctlN("raw_go", 1'b1, 1'b0); adv();
    iInst(OPC_ADI, 2'd0, 2'd1);
    settle(); ctlN("raw_p2", 1'b1, 1'b0); adv();
    iInst(OPC_ADI, 2'd0, 2'd3);
    settle(); ctlN("raw_fill1", 1'b1, 1'b0); adv();
    iInst(OPC_ADI, 2'd0, 2'd0);
    settle(); ctlN("raw_fill2", 1'b1, 1'b0); adv();
    rInst(FUNC_ADD, 2'd1, 2'd1, 2'd2);
    settle(); ctlN("raw_third_cycle", 1'b1, 1'b0); adv();
    drain(4);

    // HLT behind LWD/ADD: three DRAIN cycles then HALTED
    doReset();
    sbOn = 1'b1;
    iInst(OPC_LWD, 2'd0, 2'd1);
    settle(); expectRetire(1'b0); adv();
    rInst(FUNC_ADD, 2'd3, 2'd0, 2'd2);
    settle(); ctlF("hlt_pre_add", 1'b1, 1'b0, 1'b0); expectRetire(1'b0); adv();
    rInst(FUNC_HLT, 2'd0, 2'd0, 2'd0);
    settle();
    ctlF("hlt_take", 1'b0, 1'b0, 1'b0);
    chk("hlt_take_state", 32'(busF.dbg_state), 32'(HALT_RUN));
    adv();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("drain_state", 32'(busF.dbg_state), 32'(HALT_DRAIN));
      chk("drain_halted", 32'(busF.is_halted), 32'd0);
      ctlF("drain", 1'b0, 1'b0, 1'b0);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("halted_state", 32'(busF.dbg_state), 32'(HALT_DONE));
      chk("halted_flag", 32'(busF.is_halted), 32'd1);
      chk("halted_pc_en", 32'(busF.pc_en), 32'd0);
      adv();
    end

    // Asynchronous reset in the middle of DRAIN
    doReset();
    iInst(OPC_LWD, 2'd0, 2'd1);
    settle(); expectRetire(1'b0); adv();
    rInst(FUNC_ADD, 2'd3, 2'd0, 2'd2);
    settle(); expectRetire(1'b0); adv();
    rInst(FUNC_HLT, 2'd0, 2'd0, 2'd0);
    settle(); adv();
    settle(); adv();
    settle();
    chk("mid_drain_state", 32'(busF.dbg_state), 32'(HALT_DRAIN));
    chk("mid_drain_count", 32'(busF.num_inst), 32'd1);
    nop();
    reset = 1'b1;
    #1;
    chk("async_rst_num_inst", 32'(busF.num_inst), 32'd0);
    chk("async_rst_state", 32'(busF.dbg_state), 32'(HALT_RUN));
    chk("async_rst_halted", 32'(busF.is_halted), 32'd0);
    chk("async_rst_output_active", 32'(busF.output_active), 32'd0);
    ctlF("async_rst", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    expCnt = 0;
    cyc++;
    drain(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_hazard_unit.md
Name: pipe_ctrl_hazard_unit

Overview:
Parametrised, pipelined successor to the single-cycle TSC decode/control block.
- ID stage: decodes opcode/func_code into the control bundle latched into ID/EX.
- Scoreboard: tracks in-flight writers across PIPE_DEPTH post-ID stages; generates stall, flush and bubble.
- Retirement: retires WWD output strobes at WB and counts retired instructions.
- HLT: drains the pipeline through a RUN/DRAIN/HALTED FSM before asserting is_halted.

Parameters:
NUM_REG_W, 2, register-address width (4 GPRs).
PIPE_DEPTH, 3, stages after ID (EX, MEM, WB); minimum 2.
FORWARD_EN, 1, 1 = bypass network present (stall only on load-use); 0 = stall on any RAW.
INST_CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  IF/ID register holds a real instruction
id_opcode  in  4  instruction opcode
id_func_code  in  6  R-type function code
id_rs  in  NUM_REG_W  source register 1
id_rt  in  NUM_REG_W  source register 2
id_rd  in  NUM_REG_W  R-type destination
ex_branch_taken  in  1  EX-stage branch compare result, valid for branch in EX
id_reg_write  out  1  control bundle for ID/EX
id_reg_dst  out  2  REGDST_RT/RD/2
id_alu_src_b  out  2  ALUSRCB_REG/IMM/ZERO
id_alu_op  out  4  OP_* code
id_mem_read  out  1  LWD
id_mem_write  out  1  SWD
id_mem_to_reg  out  2  REGWRITESRC_ALU/MEM/PC
id_pc_source  out  2  PCSRC_SEQ/JUMP/REG/BRANCH
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  clear IF/ID to invalid
idex_bubble  out  1  load NOP into ID/EX
output_active  out  1  WWD retiring at WB (one-cycle pulse)
is_halted  out  1  pipeline drained after HLT
num_inst  out  INST_CNT_W  retired-instruction count

Behaviour:
Decode (combinational, gated by id_valid; all zero/SEQ when invalid or bubbled):
- R-arith: reg_write=1, dst=RD, src_b=REG, op per func.
- ADI/ORI/LHI: dst=RT, src_b=IMM, op ADD/OR/LHI.
- LWD: mem_read=1, mem_to_reg=MEM, op ADD, src_b=IMM, reg_write=1, dst=RT.
- SWD: mem_write=1, op ADD, src_b=IMM, reg_write=0.
- BNE/BEQ: src_b=REG. BGZ/BLZ: src_b=ZERO. All branches: op SUB, pc_source=BRANCH, reg_write=0.
- JMP: pc_source=JUMP. JAL: pc_source=JUMP, reg_write=1, dst=2, mem_to_reg=PC.
- JPR: pc_source=REG. JRL: pc_source=REG, reg_write=1, dst=2, mem_to_reg=PC.
- WWD, HLT: no write, pc_source=SEQ.

Source use:
- rs is read by everything except JMP, JAL, LHI, HLT.
- rt is read by R-arith (except NOT/TCP/SHL/SHR), BNE, BEQ, SWD.

Scoreboard: PIPE_DEPTH entries of {valid, reg_write, dst, is_load, is_wwd}.
- Entry 0 = EX, entry PIPE_DEPTH-1 = WB.
- Shifts every cycle.
- Entry 0 loads the ID instruction, or an empty entry when id_valid=0 or idex_bubble=1.

RAW hazard detection:
- FORWARD_EN=1: hazard only when entry 0 is_load and its dst equals a used source.
- FORWARD_EN=0: hazard on a dst match in any valid reg_write entry 0..PIPE_DEPTH-2. WB is excluded because the register file uses write-first.
- On hazard: pc_en=0, ifid_en=0, idex_bubble=1.

Control flow:
- Branch in entry 0 with ex_branch_taken=1 (predict not-taken): ifid_flush=1 and idex_bubble=1 in that cycle. This overrides any stall, and the ID instruction is discarded.
- JMP/JAL/JPR/JRL redirect from ID: ifid_flush=1 next-cycle slot, no bubble. JPR/JRL first obey the RAW stall on rs.

Retirement:
- A valid WB entry increments num_inst, wrapping modulo 2^INST_CNT_W.
- output_active=1 in the same cycle for an is_wwd WB entry.

FSM:
- RUN: valid HLT in ID with no flush moves to DRAIN. HLT is not entered into the scoreboard. pc_en=0 and ifid_en=0 from the transition onward.
- DRAIN: when all entries are invalid, move to HALTED.
- HALTED: terminal; is_halted=1 and pc_en=0. Only reset leaves this state.
- A HLT squashed by a taken branch in the same cycle is ignored.

Reset (asynchronous, any state, mid-operation included):
- Scoreboard cleared, FSM=RUN, num_inst=0, output_active=0, is_halted=0.
- pc_en=1, ifid_en=1, flush=0, bubble=0.

Decomposition:
- Opcode/func constants stay in opcodes.v.
- REGDST_*, ALUSRCB_*, REGWRITESRC_*, PCSRC_*, OP_* and the new HALT_RUN/HALT_DRAIN/HALT_DONE encodings go in constants.v.
- One sub-module, ctrl_decoder: purely combinational decode of opcode/func to the control bundle plus the rs/rt-use and is_load/is_wwd flags. The top module holds the scoreboard, hazard logic, FSM and counter.

Test Plan:
- Reset: after reset, drive ADD $1←$2+$3 then WWD $1 → num_inst=2 at 2nd WB, output_active pulses exactly one cycle at WWD WB, no stall.
- Load-use, FORWARD_EN=1: LWD $1 followed by ADD $2←$1+$0 → exactly 1 stall cycle (pc_en=0, idex_bubble=1). Repeat with ADI $2←$3+5 → 0 stalls.
- RAW, FORWARD_EN=0, PIPE_DEPTH=3: ADI $1 then ADD $2←$1+$1 → 2 stall cycles. A 3rd-cycle consumer sees none.
- Branch: BEQ $0,$0 taken with ex_branch_taken=1 → ifid_flush=1 and idex_bubble=1 in the same cycle; the squashed instruction is not counted in num_inst.
- Halt: HLT behind LWD/ADD → DRAIN for 3 cycles, then is_halted=1, pc_en held 0. Assert reset during DRAIN → is_halted=0, num_inst=0, state RUN.
- JRL $1 preceded by LWD $1 (FORWARD_EN=1) → 1 stall, then id_pc_source=REG, id_reg_dst=2, id_mem_to_reg=PC, ifid_flush=1.
